// File: rtl/ram_burst_master.sv
// Burst engine for a single-port synchronous RAM: streams write beats in and read beats out.
// Optional macro BURST_WRAP_ERR_EN rejects bursts that would cross the top of the address space.
module ram_burst_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_err,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, addr_hold_q;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W:0]          cnt_q, cnt_d;
    logic                    infl_q, infl_d, infl_last_q, infl_last_d;
    logic [1:0][DATA_W-1:0]  buf_data_q;
    logic [1:0]              buf_last_q;
    logic                    rptr_q, wptr_q;
    logic [1:0]              occ_q;

    logic                    accept, pop, wr_beat, issue, last_issue;
    logic [2:0]              pend;

    assign accept     = cmd_valid & cmd_ready;
    assign pop        = rd_valid & rd_ready;
    assign wr_beat    = (state_q == S_WRITE) & wr_valid;
    assign last_issue = (cnt_q == {1'b0, len_q});
    // Entries that will occupy the buffer once the in-flight read lands and this cycle's pop leaves.
    assign pend       = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
    assign issue      = (state_q == S_READ) && (cnt_q <= {1'b0, len_q}) && (pend < 3'd2);

`ifdef BURST_WRAP_ERR_EN
    localparam int SPAN_W = ADDR_W + LEN_W + 1;
    localparam logic [SPAN_W-1:0] ADDR_MAX = SPAN_W'((2 ** ADDR_W) - 1);
    logic bad_cmd;
    logic err_q, err_d;
    assign bad_cmd = (SPAN_W'(cmd_addr) + SPAN_W'(cmd_len)) > ADDR_MAX;
    assign cmd_err = err_q;
`else
    assign cmd_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        infl_d      = issue;
        infl_last_d = issue & last_issue;
`ifdef BURST_WRAP_ERR_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef BURST_WRAP_ERR_EN
                    if (bad_cmd) err_d = 1'b1;
                    else
`endif
                    begin
                        addr_d  = cmd_addr;
                        len_d   = cmd_len;
                        cnt_d   = '0;
                        state_d = cmd_write ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_beat) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + (LEN_W+1)'(1);
                    if (last_issue) state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + (LEN_W+1)'(1);
                end
                if (pop && rd_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            addr_hold_q <= '0;
`ifdef BURST_WRAP_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            addr_hold_q <= ram_address;
`ifdef BURST_WRAP_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Two-entry response buffer; ram_q is pushed the cycle after its address was issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_data_q <= '0;
            buf_last_q <= '0;
            rptr_q     <= 1'b0;
            wptr_q     <= 1'b0;
            occ_q      <= '0;
        end else begin
            if (infl_q) begin
                buf_data_q[wptr_q] <= ram_q;
                buf_last_q[wptr_q] <= infl_last_q;
                wptr_q             <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign wr_ready    = (state_q == S_WRITE);
    assign busy        = (state_q != S_IDLE);
    assign ram_we      = wr_beat;
    assign ram_address = ((state_q == S_WRITE) || issue) ? addr_q : addr_hold_q;
    assign ram_d       = (state_q == S_WRITE) ? wr_data : '0;
    assign rd_valid    = (occ_q != 2'd0);
    assign rd_data     = buf_data_q[rptr_q];
    assign rd_last     = rd_valid & buf_last_q[rptr_q];

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 128x32 synchronous RAM.
module tb_ram_burst_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_err;
    logic [6:0]  cmd_addr;
    logic [6:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last, busy;
    logic [31:0] rd_data;
    logic        ram_we;
    logic [6:0]  ram_address;
    logic [31:0] ram_d, ram_q;

    logic        ram_init;
    logic [31:0] mem [128];

    int n_checks = 0;
    int n_pass   = 0;

    ram_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .ram_we(ram_we), .ram_address(ram_address), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: preload 0x5000_0000+addr, registered read, write on ram_we.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h5000_0000 + i;
        end else if (ram_we) begin
            mem[ram_address] <= ram_d;
        end
        ram_q <= mem[ram_address];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ram_init = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        tick; tick; tick;
        rst_n = 1'b1; ram_init = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, cmd_err, wr_ready, rd_valid, rd_last, busy, ram_we} !== 7'b1000000)
            $display("FAIL reset_ctrl got=%b want=1000000",
                     {cmd_ready, cmd_err, wr_ready, rd_valid, rd_last, busy, ram_we});
        else n_pass++;
        n_checks++;
        if ({ram_address, ram_d} !== 39'd0)
            $display("FAIL reset_ram addr=%0d d=%h want 0/0", ram_address, ram_d);
        else n_pass++;
        tick;
    endtask

    task automatic test_write_burst;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 7'd5; cmd_len = 7'd3;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready got=%b want=1", cmd_ready);
        else n_pass++;
        tick;
        cmd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_data = 32'hA000_0000 + i;
            #1;
            n_checks++;
            if ({ram_we, wr_ready, ram_address, ram_d} !== {1'b1, 1'b1, 7'(5 + i), 32'hA000_0000 + i})
                $display("FAIL wr_beat%0d we=%b rdy=%b addr=%0d d=%h want 1/1/%0d/%h",
                         i, ram_we, wr_ready, ram_address, ram_d, 5 + i, 32'hA000_0000 + i);
            else n_pass++;
            tick;
        end
        wr_valid = 0;
        #1;
        n_checks++;
        if ({busy, ram_we, cmd_ready} !== 3'b001)
            $display("FAIL wr_done busy=%b we=%b cmd_ready=%b want 0/0/1", busy, ram_we, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_read_burst;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 7'd5; cmd_len = 7'd3;
        tick;
        cmd_valid = 0; rd_ready = 1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (rd_valid !== 1'b0) $display("FAIL rd_latency cyc%0d rd_valid=%b want 0", c, rd_valid);
            else n_pass++;
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rd_valid, rd_data, rd_last} !== {1'b1, 32'hA000_0000 + i, i == 3})
                $display("FAIL rd_beat%0d v=%b d=%h last=%b want 1/%h/%b",
                         i, rd_valid, rd_data, rd_last, 32'hA000_0000 + i, i == 3);
            else n_pass++;
            tick;
        end
        n_checks++;
        if ({busy, rd_valid, cmd_ready} !== 3'b001)
            $display("FAIL rd_done busy=%b v=%b cmd_ready=%b want 0/0/1", busy, rd_valid, cmd_ready);
        else n_pass++;
        rd_ready = 0;
    endtask

    task automatic test_backpressure;
        int k = 0;
        logic held = 0;
        logic [31:0] held_d = 0;
        logic held_l = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 7'd10; cmd_len = 7'd7;
        tick;
        cmd_valid = 0;
        for (int c = 0; c < 100 && k < 8; c++) begin
            rd_ready = (c % 3 == 0);
            #1;
            if (held) begin
                n_checks++;
                if ({rd_valid, rd_data, rd_last} !== {1'b1, held_d, held_l})
                    $display("FAIL bp_stable cyc%0d v=%b d=%h l=%b want 1/%h/%b",
                             c, rd_valid, rd_data, rd_last, held_d, held_l);
                else n_pass++;
            end
            held = 0;
            if (rd_valid) begin
                if (rd_ready) begin
                    n_checks++;
                    if ({rd_data, rd_last} !== {32'h5000_000A + k, k == 7})
                        $display("FAIL bp_beat%0d d=%h l=%b want %h/%b",
                                 k, rd_data, rd_last, 32'h5000_000A + k, k == 7);
                    else n_pass++;
                    k++;
                end else begin
                    held = 1; held_d = rd_data; held_l = rd_last;
                end
            end
            @(posedge clk); #1;
        end
        rd_ready = 0;
        n_checks++;
        if (k !== 8 || busy !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL bp_count beats=%0d busy=%b v=%b want 8/0/0", k, busy, rd_valid);
        else n_pass++;
    endtask

    task automatic test_wrap;
        int k = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 7'd126; cmd_len = 7'd3;
        tick;
        cmd_valid = 0;
`ifdef BURST_WRAP_ERR_EN
        wr_valid = 1; wr_data = 32'hB000_0000;
        #1;
        n_checks++;
        if ({cmd_err, wr_ready, busy, ram_we} !== 4'b1000)
            $display("FAIL wrap_err err=%b rdy=%b busy=%b we=%b want 1/0/0/0", cmd_err, wr_ready, busy, ram_we);
        else n_pass++;
        tick;
        wr_valid = 0;
        n_checks++;
        if (cmd_err !== 1'b0) $display("FAIL wrap_err_pulse err=%b want 0", cmd_err);
        else n_pass++;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 7'd126; cmd_len = 7'd1;
        tick;
        cmd_valid = 0; rd_ready = 1;
        for (int c = 0; c < 20 && k < 2; c++) begin
            if (rd_valid) begin
                n_checks++;
                if (rd_data !== 32'h5000_007E + k)
                    $display("FAIL wrap_keep%0d d=%h want %h", k, rd_data, 32'h5000_007E + k);
                else n_pass++;
                k++;
            end
            tick;
        end
        rd_ready = 0;
        n_checks++;
        if (k !== 2) $display("FAIL wrap_keep_count beats=%0d want 2", k);
        else n_pass++;
`else
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_data = 32'hB000_0000 + i;
            #1;
            n_checks++;
            if ({ram_we, ram_address} !== {1'b1, 7'(126 + i)})
                $display("FAIL wrap_addr%0d we=%b addr=%0d want 1/%0d", i, ram_we, ram_address, (126 + i) % 128);
            else n_pass++;
            tick;
        end
        wr_valid = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 7'd126; cmd_len = 7'd3;
        tick;
        cmd_valid = 0; rd_ready = 1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (rd_valid) begin
                n_checks++;
                if ({rd_data, rd_last} !== {32'hB000_0000 + k, k == 3})
                    $display("FAIL wrap_rd%0d d=%h l=%b want %h/%b", k, rd_data, rd_last, 32'hB000_0000 + k, k == 3);
                else n_pass++;
                k++;
            end
            tick;
        end
        rd_ready = 0;
        n_checks++;
        if (k !== 4) $display("FAIL wrap_rd_count beats=%0d want 4", k);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_burst;
        int k = 0;
        logic [31:0] exp0;
`ifdef BURST_WRAP_ERR_EN
        exp0 = 32'h5000_0000;
`else
        exp0 = 32'hB000_0002;
`endif
        cmd_valid = 1; cmd_write = 0; cmd_addr = 7'd0; cmd_len = 7'd7;
        tick;
        cmd_valid = 0; rd_ready = 1;
        tick; tick; tick; tick;
        n_checks++;
        if ({rd_valid, rd_data} !== {1'b1, 32'h5000_0002})
            $display("FAIL rst_beat2 v=%b d=%h want 1/50000002", rd_valid, rd_data);
        else n_pass++;
        rst_n = 0;
        tick;
        rst_n = 1;
        #1;
        n_checks++;
        if ({rd_valid, busy, cmd_ready} !== 3'b001)
            $display("FAIL rst_mid v=%b busy=%b cmd_ready=%b want 0/0/1", rd_valid, busy, cmd_ready);
        else n_pass++;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 7'd0; cmd_len = 7'd0;
        tick;
        cmd_valid = 0;
        for (int c = 0; c < 8; c++) begin
            if (rd_valid) begin
                n_checks++;
                if ({rd_data, rd_last} !== {exp0, 1'b1})
                    $display("FAIL rst_single d=%h l=%b want %h/1", rd_data, rd_last, exp0);
                else n_pass++;
                k++;
            end
            tick;
        end
        rd_ready = 0;
        n_checks++;
        if (k !== 1 || busy !== 1'b0) $display("FAIL rst_single_count beats=%0d busy=%b want 1/0", k, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int k = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 7'd20; cmd_len = 7'd1;
        tick;
        for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < 3; g++) begin
                wr_valid = 0;
                #1;
                n_checks++;
                if ({ram_we, cmd_ready, busy} !== 3'b001)
                    $display("FAIL b2b_gap%0d_%0d we=%b cmd_ready=%b busy=%b want 0/0/1",
                             b, g, ram_we, cmd_ready, busy);
                else n_pass++;
                tick;
            end
            wr_valid = 1; wr_data = 32'hC000_0000 + b;
            #1;
            n_checks++;
            if ({ram_we, ram_address} !== {1'b1, 7'(20 + b)})
                $display("FAIL b2b_beat%0d we=%b addr=%0d want 1/%0d", b, ram_we, ram_address, 20 + b);
            else n_pass++;
            tick;
        end
        wr_valid = 0;
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10)
            $display("FAIL b2b_idle cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        else n_pass++;
        cmd_write = 0;
        tick;
        cmd_valid = 0; rd_ready = 1;
        for (int c = 0; c < 20 && k < 2; c++) begin
            if (rd_valid) begin
                n_checks++;
                if ({rd_data, rd_last} !== {32'hC000_0000 + k, k == 1})
                    $display("FAIL b2b_rd%0d d=%h l=%b want %h/%b", k, rd_data, rd_last, 32'hC000_0000 + k, k == 1);
                else n_pass++;
                k++;
            end
            tick;
        end
        rd_ready = 0;
        n_checks++;
        if (k !== 2) $display("FAIL b2b_rd_count beats=%0d want 2", k);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_write_burst;
        test_read_burst;
        test_backpressure;
        test_wrap;
        test_reset_mid_burst;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
